// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: releases channel resets one by one in index order and
// handles button, software and per-channel soft resets. Optional macro: RST_SEQ_DEBOUNCE_EN.
module reset_sequencer #(
    parameter int NUM_CH  = 4,
    parameter int STRETCH = 16,
    parameter int DEB_LEN = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              btn_rst,
    input  logic              sw_rst,
    input  logic [NUM_CH-1:0] ch_rst_req,
    output logic [NUM_CH-1:0] rst_out,
    output logic              seq_done,
    output logic [1:0]        rst_cause
);
    localparam int CNT_W = $clog2(STRETCH + 1);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {
        SEQ  = 1'b0,
        DONE = 1'b1
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  soft_cnt_q [NUM_CH];
    logic [NUM_CH-1:0] rst_out_q;
    logic              seq_done_q;
    logic [1:0]        rst_cause_q;
    logic              btn_meta_q;
    logic              btn_sync_q;
    logic              btn_accept;

    if (NUM_CH < 1 || STRETCH < 1 || DEB_LEN < 1) begin : g_param_check
        $error("reset_sequencer: NUM_CH, STRETCH and DEB_LEN must all be >= 1");
    end

    // NOTE: non-blocking assignments let both flops sample the pre-edge values, giving a true two-stage chain.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
        end else begin
            btn_meta_q <= btn_rst;
            btn_sync_q <= btn_meta_q;
        end
    end

`ifdef RST_SEQ_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_LEN + 1);

    logic [DEB_W-1:0] deb_cnt_q;
    logic [DEB_W-1:0] deb_cnt_d;

    // NOTE: the default assignment up front keeps every path assigned, so no latch is inferred.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        if (!btn_sync_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q != DEB_W'(DEB_LEN)) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            deb_cnt_q <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Saturated count keeps a held button restarting every cycle.
    assign btn_accept = (deb_cnt_q == DEB_W'(DEB_LEN));
`else
    assign btn_accept = btn_sync_q;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst || btn_accept || sw_rst) begin
            state_q     <= SEQ;
            cnt_q       <= '0;
            idx_q       <= '0;
            rst_out_q   <= '1;
            seq_done_q  <= 1'b0;
            if (sys_rst) begin
                rst_cause_q <= 2'd0;
            end else if (btn_accept) begin
                rst_cause_q <= 2'd1;
            end else begin
                rst_cause_q <= 2'd2;
            end
            // NOTE: this counter array is live control state, not storage, so every entry is cleared here.
            for (int k = 0; k < NUM_CH; k++) begin
                soft_cnt_q[k] <= '0;
            end
        end else if (state_q == SEQ) begin
            if (cnt_q == CNT_W'(STRETCH - 1)) begin
                cnt_q            <= '0;
                idx_q            <= idx_q + 1'b1;
                rst_out_q[idx_q] <= 1'b0;
                if (idx_q == IDX_W'(NUM_CH - 1)) begin
                    state_q    <= DONE;
                    seq_done_q <= 1'b1;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            // A new request reloads the counter, so repeated requests extend the pulse.
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_rst_req[k]) begin
                    rst_out_q[k]  <= 1'b1;
                    soft_cnt_q[k] <= CNT_W'(STRETCH);
                end else if (soft_cnt_q[k] != '0) begin
                    soft_cnt_q[k] <= soft_cnt_q[k] - 1'b1;
                    if (soft_cnt_q[k] == CNT_W'(1)) begin
                        rst_out_q[k] <= 1'b0;
                    end
                end
            end
        end
    end

    assign rst_out   = rst_out_q;
    assign seq_done  = seq_done_q;
    assign rst_cause = rst_cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a default-sized and a NUM_CH=1/STRETCH=1 instance share
// one stimulus stream; expectations come from an edge-arithmetic reference model.
module tb_reset_sequencer;
    localparam int DEB  = 8;
    localparam int NI   = 2;
    localparam int MAXE = 8192;

    typedef struct {
        logic [3:0] rst;
        logic       done;
        logic [1:0] cause;
        int         edge_no;
    } exp_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       btn_rst;
    logic       sw_rst;
    logic [3:0] ch_rst_req;
    logic [3:0] rst_out_big;
    logic       seq_done_big;
    logic [1:0] rst_cause_big;
    logic [0:0] rst_out_small;
    logic       seq_done_small;
    logic [1:0] rst_cause_small;

    always #5 sys_clk = ~sys_clk;

    reset_sequencer #(.NUM_CH(4), .STRETCH(16), .DEB_LEN(DEB)) u_big (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .btn_rst    (btn_rst),
        .sw_rst     (sw_rst),
        .ch_rst_req (ch_rst_req),
        .rst_out    (rst_out_big),
        .seq_done   (seq_done_big),
        .rst_cause  (rst_cause_big)
    );

    reset_sequencer #(.NUM_CH(1), .STRETCH(1), .DEB_LEN(DEB)) u_small (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .btn_rst    (btn_rst),
        .sw_rst     (sw_rst),
        .ch_rst_req (ch_rst_req[0:0]),
        .rst_out    (rst_out_small),
        .seq_done   (seq_done_small),
        .rst_cause  (rst_cause_small)
    );

    exp_t q_big[$];
    exp_t q_small[$];

    int n_ch     [NI];
    int stretch  [NI];
    int base     [NI];
    int cause_m  [NI];
    int soft_end [NI][4];
    bit btn_hist [MAXE];
    int last_rst = 0;
    int edge_no  = 0;
    int errors   = 0;
    int checks   = 0;
    int popped   = 0;

    task automatic check(input string name, input int e, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, e, act, exp);
        end
    endtask

    // Button sample taken at edge i; anything at or before the last master reset is invisible.
    function automatic bit samp(input int i);
        if (i <= last_rst || i < 1 || i >= MAXE) return 1'b0;
        return btn_hist[i];
    endfunction

    function automatic bit btn_accepted(input int t);
`ifdef RST_SEQ_DEBOUNCE_EN
        for (int j = 3; j <= DEB + 2; j++) begin
            if (!samp(t - j)) return 1'b0;
        end
        return 1'b1;
`else
        return samp(t - 2);
`endif
    endfunction

    // Drive one cycle of stimulus, predict the outputs after the coming edge, then let it happen.
    task automatic issue(input logic rst, input logic btn, input logic sw, input logic [3:0] req);
        exp_t e;
        bit   acc;
        int   t;
        sys_rst    = rst;
        btn_rst    = btn;
        sw_rst     = sw;
        ch_rst_req = req;
        edge_no++;
        t = edge_no;
        if (rst) last_rst = t;
        else if (t < MAXE) btn_hist[t] = btn;
        acc = !rst && btn_accepted(t);
        for (int i = 0; i < NI; i++) begin
            if (rst || acc || sw) begin
                base[i]    = t;
                cause_m[i] = rst ? 0 : (acc ? 1 : 2);
                for (int k = 0; k < 4; k++) soft_end[i][k] = 0;
            end else if (t - 1 - base[i] >= n_ch[i] * stretch[i]) begin
                for (int k = 0; k < n_ch[i]; k++) begin
                    if (req[k]) soft_end[i][k] = t + stretch[i];
                end
            end
            e.rst = '0;
            for (int k = 0; k < n_ch[i]; k++) begin
                e.rst[k] = (t - base[i] < (k + 1) * stretch[i]) || (t < soft_end[i][k]);
            end
            e.done    = (t - base[i] >= n_ch[i] * stretch[i]);
            e.cause   = 2'(cause_m[i]);
            e.edge_no = t;
            if (i == 0) q_big.push_back(e);
            else        q_small.push_back(e);
        end
        @(posedge sys_clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) issue(1'b0, 1'b0, 1'b0, 4'b0000);
    endtask

    initial begin : monitor
        exp_t eb;
        exp_t es;
        forever begin
            @(posedge sys_clk);
            #1;
            if (q_big.size() > 0 && q_small.size() > 0) begin
                eb = q_big.pop_front();
                es = q_small.pop_front();
                popped++;
                check("big.rst_out",     eb.edge_no, 32'(rst_out_big),     32'(eb.rst));
                check("big.seq_done",    eb.edge_no, 32'(seq_done_big),    32'(eb.done));
                check("big.rst_cause",   eb.edge_no, 32'(rst_cause_big),   32'(eb.cause));
                check("small.rst_out",   es.edge_no, 32'(rst_out_small),   32'(es.rst));
                check("small.seq_done",  es.edge_no, 32'(seq_done_small),  32'(es.done));
                check("small.rst_cause", es.edge_no, 32'(rst_cause_small), 32'(es.cause));
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic       r;
        logic       b;
        logic       s;
        logic [3:0] q;
        int         btn_left;
        n_ch    = '{4, 1};
        stretch = '{16, 1};
        btn_left = 0;

        // Power-up and full sequence.
        repeat (5) issue(1'b1, 1'b0, 1'b0, 4'b0000);
        idle(70);
        // Soft reset extended by a second request 10 cycles later, then overlapping channels.
        issue(1'b0, 1'b0, 1'b0, 4'b0100);
        idle(9);
        issue(1'b0, 1'b0, 1'b0, 4'b0100);
        idle(30);
        issue(1'b0, 1'b0, 1'b0, 4'b0001);
        idle(5);
        issue(1'b0, 1'b0, 1'b0, 4'b1000);
        idle(20);
        // Software restart, then another at E40 mid-sequence with an ignored soft request.
        issue(1'b0, 1'b0, 1'b1, 4'b0000);
        idle(39);
        issue(1'b0, 1'b0, 1'b1, 4'b0000);
        idle(5);
        issue(1'b0, 1'b0, 1'b0, 4'b0100);
        idle(70);
        // Short button glitch, then a 12-cycle press.
        repeat (3) issue(1'b0, 1'b1, 1'b0, 4'b0000);
        idle(30);
        repeat (12) issue(1'b0, 1'b1, 1'b0, 4'b0000);
        idle(80);
        // Button accepted while software restart pulses: button wins.
        repeat (10) issue(1'b0, 1'b1, 1'b0, 4'b0000);
        repeat (4) issue(1'b0, 1'b1, 1'b1, 4'b0000);
        idle(80);
        // Master reset in the middle of a soft reset.
        issue(1'b0, 1'b0, 1'b0, 4'b0010);
        idle(5);
        repeat (2) issue(1'b1, 1'b0, 1'b0, 4'b0000);
        idle(70);

        // Random traffic.
        for (int c = 0; c < 2500; c++) begin
            r = ($urandom_range(399) == 0);
            if (btn_left == 0 && $urandom_range(299) == 0) btn_left = $urandom_range(15, 1);
            b = (btn_left > 0);
            if (btn_left > 0) btn_left--;
            s = ($urandom_range(249) == 0);
            q = '0;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(11) == 0) q[k] = 1'b1;
            end
            issue(r, b, s, q);
        end

        check("scoreboard_drained", edge_no, 32'(popped), 32'(edge_no));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
